hockey_game_ctrl: RTL and testbench

Two-player match controller for the DigiHockey puck datapath on a 5x5 field (X, Y in 0..4). It sequences serves, steps the puck at a divided tick rate with wall bounces, and opens a hit window at each goal line. It scores misses and declares the winner. It sits between the player button/switch inputs and the display driver, which consumes the X_COORD/Y_COORD/SCORE outputs.

---
 rtl/hockey_pkg.sv | 44 ++++
 rtl/hockey_tick_gen.sv | 28 ++
 rtl/hockey_game_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_hockey_game_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hockey_pkg.sv
// Shared types and helpers for the DigiHockey match controller: FSM states,
// puck direction codes, field limits and the paddle-row clamp.
package hockey_pkg;

   typedef enum logic [3:0] {
      IDLE,
      SERVE_A,
      SERVE_B,
      MOVE_R,
      HIT_B,
      MOVE_L,
      HIT_A,
      GOAL,
      OVER
   } state_t;

   typedef enum logic [1:0] {
      DIR_STRAIGHT = 2'b00,
      DIR_UP       = 2'b01,
      DIR_DOWN     = 2'b10
   } dir_t;

   typedef struct packed {
      dir_t       dir;
      logic [2:0] y;
   } vstep_t;

   localparam logic [2:0] X_MAX = 3'd4;
   localparam logic [2:0] Y_MAX = 3'd4;

   function automatic logic [2:0] clamp(input logic [2:0] v);
      return (v > Y_MAX) ? Y_MAX : v;
   endfunction

   // Code 11 has no meaning of its own and is played as a straight shot.
   function automatic dir_t decode_dir(input logic [1:0] d);
      case (d)
         2'b01:   return DIR_UP;
         2'b10:   return DIR_DOWN;
         default: return DIR_STRAIGHT;
      endcase
   endfunction

endpackage

// File: rtl/hockey_tick_gen.sv
// Puck step-rate divider: one-cycle tick every TICK_DIV clocks; restart
// re-phases the divider so the next tick lands a full period later.
module hockey_tick_gen #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (restart || cnt_q == LAST)
         cnt_q <= '0;
      else
         cnt_q <= cnt_q + 1'b1;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/hockey_game_ctrl.sv
// Two-player DigiHockey match controller: serves, puck stepping with wall
// bounces, goal-line hit windows, scoring and winner. Optional auto-serve
// after SERVE_TIMEOUT idle ticks is enabled by defining HOCKEY_SERVE_TIMEOUT_EN.
module hockey_game_ctrl
   import hockey_pkg::*;
#(
   parameter int TICK_DIV      = 4,
   parameter int WIN_SCORE     = 3,
   parameter int GOAL_HOLD     = 2,
   parameter int SERVE_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       BTN_A,
   input  logic       BTN_B,
   input  logic [1:0] DIR_A,
   input  logic [1:0] DIR_B,
   input  logic [2:0] Y_IN_A,
   input  logic [2:0] Y_IN_B,
   output logic [2:0] X_COORD,
   output logic [2:0] Y_COORD,
   output logic [2:0] SCORE_A,
   output logic [2:0] SCORE_B,
   output logic       TURN,
   output logic       GAME_OVER,
   output logic       WINNER
);

   localparam logic [2:0]        WIN          = 3'(WIN_SCORE);
   localparam logic [2:0]        SERVE_Y_AUTO = 3'd2;
   localparam int                HOLD_W       = (GOAL_HOLD > 1) ? $clog2(GOAL_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'((GOAL_HOLD > 0) ? GOAL_HOLD - 1 : 0);

   state_t            state_q, state_d;
   logic [2:0]        x_q, x_d, y_q, y_d;
   dir_t              dir_q, dir_d;
   logic [2:0]        score_a_q, score_a_d, score_b_q, score_b_d;
   logic              turn_q, turn_d, over_q, over_d, winner_q, winner_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              tick, restart, auto_serve, hit_a, hit_b;
   vstep_t            vs;

   function automatic logic [2:0] sat_inc(input logic [2:0] s);
      return (s >= WIN) ? WIN : s + 3'd1;
   endfunction

   // One vertical step; the wall at either edge flips the direction.
   function automatic vstep_t step_vert(input logic [2:0] y, input dir_t d);
      vstep_t r;
      r.y   = y;
      r.dir = d;
      case (d)
         DIR_UP: begin
            if (y < Y_MAX) r.y = y + 3'd1;
            else begin
               r.y   = y - 3'd1;
               r.dir = DIR_DOWN;
            end
         end
         DIR_DOWN: begin
            if (y > 3'd0) r.y = y - 3'd1;
            else begin
               r.y   = y + 3'd1;
               r.dir = DIR_UP;
            end
         end
         default: r.y = y;
      endcase
      return r;
   endfunction

   hockey_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

`ifdef HOCKEY_SERVE_TIMEOUT_EN
   localparam int            TO_W    = (SERVE_TIMEOUT > 1) ? $clog2(SERVE_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(SERVE_TIMEOUT - 1);

   logic [TO_W-1:0] to_q;
   logic            in_serve;

   assign in_serve   = (state_q == SERVE_A) || (state_q == SERVE_B);
   assign auto_serve = in_serve && tick && (to_q == TO_LAST);

   // Counts ticks spent waiting in a serve state; cleared whenever we leave.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         to_q <= '0;
      else if (in_serve && state_d == state_q)
         to_q <= tick ? to_q + 1'b1 : to_q;
      else
         to_q <= '0;
   end
`else
   assign auto_serve = 1'b0;
`endif

   assign hit_a = BTN_A && (clamp(Y_IN_A) == y_q);
   assign hit_b = BTN_B && (clamp(Y_IN_B) == y_q);

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      dir_d     = dir_q;
      score_a_d = score_a_q;
      score_b_d = score_b_q;
      turn_d    = turn_q;
      over_d    = over_q;
      winner_d  = winner_q;
      hold_d    = hold_q;
      restart   = 1'b0;
      vs        = step_vert(y_q, dir_q);
      case (state_q)
         IDLE: begin
            if (BTN_A)      state_d = SERVE_A;
            else if (BTN_B) state_d = SERVE_B;
         end
         SERVE_A: begin
            if (BTN_A || auto_serve) begin
               x_d     = 3'd0;
               y_d     = BTN_A ? clamp(Y_IN_A) : SERVE_Y_AUTO;
               dir_d   = BTN_A ? decode_dir(DIR_A) : DIR_STRAIGHT;
               turn_d  = 1'b0;
               restart = 1'b1;
               state_d = MOVE_R;
            end
         end
         SERVE_B: begin
            if (BTN_B || auto_serve) begin
               x_d     = X_MAX;
               y_d     = BTN_B ? clamp(Y_IN_B) : SERVE_Y_AUTO;
               dir_d   = BTN_B ? decode_dir(DIR_B) : DIR_STRAIGHT;
               turn_d  = 1'b1;
               restart = 1'b1;
               state_d = MOVE_L;
            end
         end
         MOVE_R: begin
            if (tick) begin
               x_d   = x_q + 3'd1;
               y_d   = vs.y;
               dir_d = vs.dir;
               if (x_q == X_MAX - 3'd1) state_d = HIT_B;
            end
         end
         MOVE_L: begin
            if (tick) begin
               x_d   = x_q - 3'd1;
               y_d   = vs.y;
               dir_d = vs.dir;
               if (x_q == 3'd1) state_d = HIT_A;
            end
         end
         // A return takes priority over the window-closing tick.
         HIT_B: begin
            if (hit_b) begin
               dir_d   = decode_dir(DIR_B);
               turn_d  = 1'b1;
               restart = 1'b1;
               state_d = MOVE_L;
            end else if (tick) begin
               score_a_d = sat_inc(score_a_q);
               hold_d    = '0;
               state_d   = GOAL;
            end
         end
         HIT_A: begin
            if (hit_a) begin
               dir_d   = decode_dir(DIR_A);
               turn_d  = 1'b0;
               restart = 1'b1;
               state_d = MOVE_R;
            end else if (tick) begin
               score_b_d = sat_inc(score_b_q);
               hold_d    = '0;
               state_d   = GOAL;
            end
         end
         // TURN still names the shooter, who is the player that just scored.
         GOAL: begin
            if (tick) begin
               if (hold_q == HOLD_LAST) begin
                  if ((turn_q ? score_b_q : score_a_q) == WIN) begin
                     over_d   = 1'b1;
                     winner_d = turn_q;
                     state_d  = OVER;
                  end else begin
                     state_d = turn_q ? SERVE_A : SERVE_B;
                  end
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         OVER: begin
            if (BTN_A && BTN_B) begin
               x_d       = 3'd0;
               y_d       = 3'd0;
               dir_d     = DIR_STRAIGHT;
               score_a_d = 3'd0;
               score_b_d = 3'd0;
               turn_d    = 1'b0;
               over_d    = 1'b0;
               winner_d  = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         x_q       <= 3'd0;
         y_q       <= 3'd0;
         dir_q     <= DIR_STRAIGHT;
         score_a_q <= 3'd0;
         score_b_q <= 3'd0;
         turn_q    <= 1'b0;
         over_q    <= 1'b0;
         winner_q  <= 1'b0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dir_q     <= dir_d;
         score_a_q <= score_a_d;
         score_b_q <= score_b_d;
         turn_q    <= turn_d;
         over_q    <= over_d;
         winner_q  <= winner_d;
         hold_q    <= hold_d;
      end
   end

   assign X_COORD   = x_q;
   assign Y_COORD   = y_q;
   assign SCORE_A   = score_a_q;
   assign SCORE_B   = score_b_q;
   assign TURN      = turn_q;
   assign GAME_OVER = over_q;
   assign WINNER    = winner_q;

endmodule

// File: tb/tb_hockey_game_ctrl.sv
// Bench for hockey_game_ctrl: a velocity-based match model checked every
// cycle, plus hand-computed positions and scores along a directed rally.
module tb_hockey_game_ctrl;
   import hockey_pkg::*;

   localparam int TD = 1;
   localparam int WS = 2;
   localparam int GH = 2;
   localparam int ST = 16;

   localparam int PH_IDLE  = 0;
   localparam int PH_SERVE = 1;
   localparam int PH_FLY   = 2;
   localparam int PH_WIN   = 3;
   localparam int PH_GOAL  = 4;
   localparam int PH_OVER  = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       BTN_A, BTN_B;
   logic [1:0] DIR_A, DIR_B;
   logic [2:0] Y_IN_A, Y_IN_B;
   logic [2:0] X_COORD, Y_COORD, SCORE_A, SCORE_B;
   logic       TURN, GAME_OVER, WINNER;

   int checks = 0;
   int errors = 0;

   int m_phase, m_srv, m_x, m_y, m_vx, m_vy, m_sa, m_sb;
   int m_turn, m_over, m_win, m_hold, m_to;

   always #5 clk = ~clk;

   hockey_game_ctrl #(
      .TICK_DIV(TD), .WIN_SCORE(WS), .GOAL_HOLD(GH), .SERVE_TIMEOUT(ST)
   ) dut (
      .clk(clk), .rst(rst),
      .BTN_A(BTN_A), .BTN_B(BTN_B),
      .DIR_A(DIR_A), .DIR_B(DIR_B),
      .Y_IN_A(Y_IN_A), .Y_IN_B(Y_IN_B),
      .X_COORD(X_COORD), .Y_COORD(Y_COORD),
      .SCORE_A(SCORE_A), .SCORE_B(SCORE_B),
      .TURN(TURN), .GAME_OVER(GAME_OVER), .WINNER(WINNER)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clampi(input int v);
      return (v > 4) ? 4 : v;
   endfunction

   function automatic int dir_vel(input int d);
      return (d == 1) ? 1 : ((d == 2) ? -1 : 0);
   endfunction

   task automatic model_reset();
      m_phase = PH_IDLE; m_srv = 0; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0;
      m_sa = 0; m_sb = 0; m_turn = 0; m_over = 0; m_win = 0; m_hold = 0; m_to = 0;
   endtask

   task automatic launch(input int who, input int row, input int vy);
      m_x = who ? 4 : 0; m_y = row; m_vy = vy; m_vx = who ? -1 : 1;
      m_turn = who; m_phase = PH_FLY;
   endtask

   // Every cycle is a tick with TD=1, so each call advances one puck step.
   task automatic model_step();
      int press, def;
      case (m_phase)
         PH_IDLE: begin
            if (BTN_A)      begin m_srv = 0; m_phase = PH_SERVE; m_to = 0; end
            else if (BTN_B) begin m_srv = 1; m_phase = PH_SERVE; m_to = 0; end
         end
         PH_SERVE: begin
            press = m_srv ? int'(BTN_B) : int'(BTN_A);
            if (press != 0)
               launch(m_srv, clampi(m_srv ? int'(Y_IN_B) : int'(Y_IN_A)),
                      dir_vel(m_srv ? int'(DIR_B) : int'(DIR_A)));
            else begin
               m_to++;
`ifdef HOCKEY_SERVE_TIMEOUT_EN
               if (m_to == ST) launch(m_srv, 2, 0);
`endif
            end
         end
         PH_FLY: begin
            m_x += m_vx;
            if (m_y + m_vy > 4 || m_y + m_vy < 0) m_vy = -m_vy;
            m_y += m_vy;
            if (m_x == 0 || m_x == 4) m_phase = PH_WIN;
         end
         PH_WIN: begin
            def   = (m_x == 4) ? 1 : 0;
            press = def ? int'(BTN_B && clampi(int'(Y_IN_B)) == m_y)
                        : int'(BTN_A && clampi(int'(Y_IN_A)) == m_y);
            if (press != 0) begin
               m_vx = -m_vx; m_vy = dir_vel(def ? int'(DIR_B) : int'(DIR_A));
               m_turn = def; m_phase = PH_FLY;
            end else begin
               if (m_turn == 0) m_sa = (m_sa < WS) ? m_sa + 1 : WS;
               else             m_sb = (m_sb < WS) ? m_sb + 1 : WS;
               m_hold = GH; m_phase = PH_GOAL;
            end
         end
         PH_GOAL: begin
            m_hold--;
            if (m_hold <= 0) begin
               if ((m_turn ? m_sb : m_sa) == WS) begin
                  m_over = 1; m_win = m_turn; m_phase = PH_OVER;
               end else begin
                  m_srv = 1 - m_turn; m_to = 0; m_phase = PH_SERVE;
               end
            end
         end
         default: begin
            if (BTN_A && BTN_B) model_reset();
         end
      endcase
   endtask

   task automatic compare_model();
      check("model_x", int'(X_COORD), m_x);
      check("model_y", int'(Y_COORD), m_y);
      check("model_score_a", int'(SCORE_A), m_sa);
      check("model_score_b", int'(SCORE_B), m_sb);
      check("model_turn", int'(TURN), m_turn);
      check("model_game_over", int'(GAME_OVER), m_over);
      check("model_winner", int'(WINNER), m_win);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (!rst) model_step();
      @(negedge clk);
      compare_model();
   endtask

   task automatic expect_pos(input string name, input int x, input int y);
      check({name, "_x"}, int'(X_COORD), x);
      check({name, "_y"}, int'(Y_COORD), y);
   endtask

   task automatic expect_state(input string name, input state_t s);
      check(name, int'(dut.state_q), int'(s));
   endtask

   task automatic expect_zero(input string name);
      check({name, "_x"}, int'(X_COORD), 0);
      check({name, "_y"}, int'(Y_COORD), 0);
      check({name, "_sa"}, int'(SCORE_A), 0);
      check({name, "_sb"}, int'(SCORE_B), 0);
      check({name, "_turn"}, int'(TURN), 0);
      check({name, "_over"}, int'(GAME_OVER), 0);
      check({name, "_winner"}, int'(WINNER), 0);
      expect_state({name, "_state"}, IDLE);
   endtask

   initial begin
      rst = 1'b1;
      BTN_A = 1'b0; BTN_B = 1'b0; DIR_A = 2'b00; DIR_B = 2'b00;
      Y_IN_A = 3'd0; Y_IN_B = 3'd0;
      model_reset();
      repeat (2) @(negedge clk);
      expect_zero("reset");
      rst = 1'b0;
      cyc(); cyc();

      // Both buttons in IDLE: A has priority.
      BTN_A = 1'b1; BTN_B = 1'b1;
      cyc(); expect_state("both_idle", SERVE_A);
      BTN_B = 1'b0; Y_IN_A = 3'd3; DIR_A = 2'b01;
      cyc(); expect_pos("serve", 0, 3); check("serve_turn", int'(TURN), 0);
      BTN_A = 1'b0;
      cyc(); expect_pos("mv1", 1, 4);
      cyc(); expect_pos("mv2", 2, 3);
      cyc(); expect_pos("mv3", 3, 2);
      cyc(); expect_pos("mv4", 4, 1); expect_state("hit_b_entry", HIT_B);

      // B misses.
      cyc(); check("miss_score_a", int'(SCORE_A), 1); check("goal_x0", int'(X_COORD), 4);
      cyc(); check("goal_x1", int'(X_COORD), 4); expect_state("goal_hold", GOAL);
      cyc(); expect_state("concede_serve_b", SERVE_B);

      // B serves from row 6 (clamps to 4) with code 11 (straight).
      BTN_B = 1'b1; Y_IN_B = 3'd6; DIR_B = 2'b11;
      cyc(); expect_pos("serve_b", 4, 4); check("serve_b_turn", int'(TURN), 1);
      BTN_B = 1'b0;
      BTN_A = 1'b1; Y_IN_A = 3'd5; DIR_A = 2'b10;
      cyc(); expect_pos("ml1", 3, 4);
      cyc(); cyc();
      cyc(); expect_pos("ml4", 0, 4); expect_state("hit_a_entry", HIT_A);
      // Hit and window-closing tick coincide: the return wins.
      cyc(); expect_state("return", MOVE_R); check("return_turn", int'(TURN), 0);
      check("return_no_score", int'(SCORE_B), 0);
      BTN_A = 1'b0;
      cyc(); expect_pos("rr1", 1, 3);
      cyc(); cyc();
      cyc(); expect_pos("rr4", 4, 0);

      // Second miss by B ends the match.
      cyc(); cyc(); cyc();
      check("over_flag", int'(GAME_OVER), 1);
      check("over_winner", int'(WINNER), 0);
      check("over_score_a", int'(SCORE_A), 2);
      BTN_A = 1'b1; cyc(); expect_state("over_hold_a", OVER);
      BTN_A = 1'b0; BTN_B = 1'b1; cyc(); expect_state("over_hold_b", OVER);
      BTN_A = 1'b1; cyc();
      expect_zero("clear");
      BTN_A = 1'b0; BTN_B = 1'b0; cyc();

      // Serve down from row 1, bounce off row 0, then reset at X=2.
      BTN_A = 1'b1; Y_IN_A = 3'd1; DIR_A = 2'b10;
      cyc(); cyc(); expect_pos("dn0", 0, 1);
      BTN_A = 1'b0;
      cyc(); expect_pos("dn1", 1, 0);
      cyc(); expect_pos("dn2", 2, 1);
      rst = 1'b1;
      #1;
      expect_zero("midrally_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b0;

      // Waiting in SERVE_B.
      BTN_B = 1'b1; cyc(); BTN_B = 1'b0;
      Y_IN_B = 3'd2; DIR_B = 2'b00;
      repeat (ST) cyc();
`ifdef HOCKEY_SERVE_TIMEOUT_EN
      expect_pos("auto_serve", 4, 2); check("auto_turn", int'(TURN), 1);
`else
      expect_state("serve_wait", SERVE_B);
      BTN_B = 1'b1; cyc(); BTN_B = 1'b0;
      expect_pos("late_serve", 4, 2); check("late_turn", int'(TURN), 1);
`endif
      cyc(); expect_pos("st1", 3, 2);
      cyc(); cyc();
      cyc(); expect_pos("st4", 0, 2);
      // A misses: B scores and A serves next.
      cyc(); check("miss_score_b", int'(SCORE_B), 1);
      cyc(); cyc(); expect_state("concede_serve_a", SERVE_A);
      check("final_score_a", int'(SCORE_A), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
